axil_master_arbiter: RTL and testbench

Shares one AXI-Lite master port between NUM_REQ local requesters. Each requester uses a simple request/response interface. Requesters are granted in round-robin order. Exactly one transaction is in flight at a time, and the block drives all five AXI-Lite channels for it. The block sits between the register-access clients and the interconnect, in front of the AXI-Lite slave.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_rr_arb.sv | 33 +++
 rtl/axil_master_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axil_master_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI-Lite widths, response codes and the arbiter FSM encoding.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_e;

endpackage

// File: rtl/axil_rr_arb.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module axil_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    // k = NUM_REQ revisits ptr itself, so the last winner is considered last
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin sharing of one AXI-Lite master port among NUM_REQ requesters,
// one transaction in flight at a time.
//
// state   | meaning
// IDLE    | arbitrate; grant is req_ready in the same cycle
// WR      | AW and W valid, each dropped on its own handshake
// WR_RESP | bready high, waiting for B
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for R
module axil_master_arbiter
  import axil_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter logic [2:0] PROT    = 3'b000
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic [31:0]            axi_awaddr,
  output logic [2:0]             axi_awprot,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [31:0]            axi_wdata,
  output logic [3:0]             axi_wstrb,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  input  logic [1:0]             axi_bresp,
  input  logic                   axi_bvalid,
  output logic                   axi_bready,
  output logic [31:0]            axi_araddr,
  output logic [2:0]             axi_arprot,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [31:0]            axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rvalid,
  output logic                   axi_rready
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, grant_idx;
  logic [NUM_REQ-1:0]     grant;
  logic                   grant_valid, arb_en;
  logic [AXIL_ADDR_W-1:0] addr_q;
  logic [AXIL_DATA_W-1:0] wdata_q;
  logic [AXIL_STRB_W-1:0] wstrb_q;
  logic                   aw_done_q, w_done_q;
  logic                   aw_fire, w_fire, complete;

  // Gated by reset so req_ready cannot pulse while the block is held in reset
  assign arb_en = (state_q == IDLE) && !areset;

  axil_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req         (req_valid),
    .ptr         (ptr_q),
    .en          (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready  = grant;
  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_awprot = PROT;
  assign axi_arprot = PROT;

  always_comb begin
    state_d     = state_q;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    aw_fire     = 1'b0;
    w_fire      = 1'b0;
    complete    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) state_d = req_write[grant_idx] ? WR : RD_ADDR;
      end
      WR: begin
        axi_awvalid = !aw_done_q;
        axi_wvalid  = !w_done_q;
        aw_fire     = axi_awvalid && axi_awready;
        w_fire      = axi_wvalid && axi_wready;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
      end
      WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;
      if (state_q == IDLE && grant_valid) begin
        ptr_q     <= grant_idx;
        owner_q   <= grant_idx;
        addr_q    <= req_addr[grant_idx*AXIL_ADDR_W +: AXIL_ADDR_W];
        wdata_q   <= req_wdata[grant_idx*AXIL_DATA_W +: AXIL_DATA_W];
        wstrb_q   <= req_wstrb[grant_idx*AXIL_STRB_W +: AXIL_STRB_W];
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      if (complete) begin
        rsp_valid <= NUM_REQ'(1) << owner_q;
        if (state_q == RD_DATA) begin
          rsp_rdata <= axi_rdata;
          rsp_resp  <= axi_rresp;
        end else begin
          rsp_resp  <= axi_bresp;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Randomized bench for axil_master_arbiter: transaction-level requester and
// slave model, cycle-by-cycle comparison of every DUT output.
module tb_axil_master_arbiter;
  import axil_pkg::*;

  localparam int N = 4;

  logic            aclk, areset;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [31:0]     rsp_rdata, axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [1:0]      rsp_resp, axi_bresp, axi_rresp;
  logic [2:0]      axi_awprot, axi_arprot;
  logic [3:0]      axi_wstrb;
  logic            axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic            axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic            axi_rvalid, axi_rready;

  axil_master_arbiter #(.NUM_REQ(N), .PROT(3'b000)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester side
  bit          pend [N];
  bit          p_wr [N];
  logic [31:0] p_addr [N], p_wdata [N];
  logic [3:0]  p_strb [N];
  int          req_mode;  // 0 directed, 1 random, 2 everyone always requesting

  // transaction model
  int          m_ptr, m_owner;
  bit          m_idle, m_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [1:0]  m_resp;
  int          cyc, last_grant_cyc, last_rsp_cyc;
  logic [N-1:0] last_rsp_vec;
  int          grant_log [$];

  // slave model
  bit          got_aw, got_w, got_ar, cmpl_next, cmpl_rd, junk, rnd_wait, use_rd;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r, cfg_resp;
  int          aw_valid_cyc, w_valid_cyc;
  logic [1:0]  cur_bresp, cur_rresp, cmpl_resp;
  logic [31:0] cur_rdata, cmpl_rdata, cfg_rdata;

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic post_req(input int i, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wdata[i] = d; p_strb[i] = s;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 2) == 0)))
        post_req(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(0, 15)));
      req_valid[i]          = pend[i];
      req_write[i]          = pend[i] ? p_wr[i] : 1'($urandom);
      req_addr[i*32 +: 32]  = pend[i] ? p_addr[i] : $urandom;
      req_wdata[i*32 +: 32] = pend[i] ? p_wdata[i] : $urandom;
      req_wstrb[i*4 +: 4]   = pend[i] ? p_strb[i] : 4'($urandom);
    end
  endtask

  task automatic model_reset();
    m_ptr = N - 1; m_idle = 1'b1; m_owner = 0; m_wr = 1'b0;
    m_rdata = '0; m_resp = '0;
    got_aw = 0; got_w = 0; got_ar = 0; cmpl_next = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
    axi_bresp = '0; axi_rresp = '0; axi_rdata = '0;
  endtask

  task automatic step();
    logic [N-1:0] exp_rsp, exp_rdy;
    int g;
    @(negedge aclk);
    cyc++;
    exp_rsp = '0;
    if (cmpl_next) begin
      exp_rsp[m_owner] = 1'b1;
      m_resp = cmpl_resp;
      if (cmpl_rd) m_rdata = cmpl_rdata;
      m_idle = 1'b1; cmpl_next = 1'b0;
      last_rsp_cyc = cyc; last_rsp_vec = rsp_valid;
    end
    chk("rsp_valid", rsp_valid, exp_rsp);
    chk("rsp_resp", rsp_resp, m_resp);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("awvalid", axi_awvalid, !m_idle && m_wr && !got_aw);
    chk("wvalid", axi_wvalid, !m_idle && m_wr && !got_w);
    chk("bready", axi_bready, !m_idle && m_wr && got_aw && got_w);
    chk("arvalid", axi_arvalid, !m_idle && !m_wr && !got_ar);
    chk("rready", axi_rready, !m_idle && !m_wr && got_ar);
    chk("awprot", axi_awprot, 3'b000);
    chk("arprot", axi_arprot, 3'b000);
    if (axi_awvalid && !m_idle) chk("awaddr", axi_awaddr, m_addr);
    if (axi_wvalid && !m_idle) begin
      chk("wdata", axi_wdata, m_wdata);
      chk("wstrb", axi_wstrb, m_strb);
    end
    if (axi_arvalid && !m_idle) chk("araddr", axi_araddr, m_addr);

    // B is decided before AW/W so a response never precedes its handshakes
    axi_bvalid = 1'b0; axi_bresp = 2'($urandom);
    if (got_aw && got_w) begin
      if (b_cnt > 0) b_cnt--;
      else begin
        axi_bvalid = 1'b1; axi_bresp = cur_bresp;
        if (axi_bready) begin
          cmpl_next = 1; cmpl_rd = 0; cmpl_resp = cur_bresp; got_aw = 0; got_w = 0;
        end
      end
    end else if (junk && $urandom_range(0, 7) == 0) axi_bvalid = 1'b1;
    axi_awready = 1'b0;
    if (axi_awvalid) begin
      aw_valid_cyc++;
      if (aw_cnt > 0) aw_cnt--; else begin axi_awready = 1'b1; got_aw = 1; end
    end
    axi_wready = 1'b0;
    if (axi_wvalid) begin
      w_valid_cyc++;
      if (w_cnt > 0) w_cnt--; else begin axi_wready = 1'b1; got_w = 1; end
    end
    axi_rvalid = 1'b0; axi_rdata = $urandom; axi_rresp = 2'($urandom);
    if (got_ar) begin
      if (r_cnt > 0) r_cnt--;
      else begin
        axi_rvalid = 1'b1; axi_rdata = cur_rdata; axi_rresp = cur_rresp;
        if (axi_rready) begin
          cmpl_next = 1; cmpl_rd = 1; cmpl_resp = cur_rresp; cmpl_rdata = cur_rdata;
          got_ar = 0;
        end
      end
    end else if (junk && $urandom_range(0, 7) == 0) axi_rvalid = 1'b1;
    axi_arready = 1'b0;
    if (axi_arvalid) begin
      if (ar_cnt > 0) ar_cnt--; else begin axi_arready = 1'b1; got_ar = 1; end
    end

    drive_reqs();
    #1;
    g = m_idle ? rr_pick() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      pend[g] = 1'b0; m_owner = g; m_ptr = g; m_idle = 1'b0;
      m_wr = p_wr[g]; m_addr = p_addr[g]; m_wdata = p_wdata[g]; m_strb = p_strb[g];
      grant_log.push_back(g); last_grant_cyc = cyc;
      aw_cnt = rnd_wait ? $urandom_range(0, 3) : cfg_aw;
      w_cnt  = rnd_wait ? $urandom_range(0, 3) : cfg_w;
      b_cnt  = rnd_wait ? $urandom_range(0, 3) : cfg_b;
      ar_cnt = rnd_wait ? $urandom_range(0, 3) : cfg_ar;
      r_cnt  = rnd_wait ? $urandom_range(0, 3) : cfg_r;
      cur_bresp = (cfg_resp < 0) ? 2'($urandom) : 2'(cfg_resp);
      cur_rresp = (cfg_resp < 0) ? 2'($urandom) : 2'(cfg_resp);
      cur_rdata = use_rd ? cfg_rdata : $urandom;
      aw_valid_cyc = 0; w_valid_cyc = 0;
    end
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    do begin step(); n++; end
    while (!(m_idle && !cmpl_next && !any_pend()) && n < max);
    chk("idle_reached", m_idle && !cmpl_next && !any_pend(), 1);
  endtask

  task automatic apply_reset(input bit with_reqs);
    #1 areset = 1'b1;
    model_reset();
    if (with_reqs) for (int i = 0; i < N; i++) post_req(i, 1'b0, 32'h100 * i, '0, '0);
    drive_reqs();
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_awaddr", axi_awaddr, 0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    areset = 1'b1; req_mode = 0; junk = 0; rnd_wait = 0; use_rd = 0; cfg_resp = 0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_rdata = '0;
    cyc = 0; last_rsp_vec = '0;
    apply_reset(1'b0);

    // zero-wait write latency
    post_req(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    run_until_idle(50);
    chk("t1_owner", grant_log[grant_log.size()-1], 1);
    chk("t1_latency", last_rsp_cyc - last_grant_cyc, 3);
    chk("t1_rsp_vec", last_rsp_vec, 4'b0010);

    // read with three R wait cycles
    cfg_r = 3; use_rd = 1; cfg_rdata = 32'h12345678;
    post_req(0, 1'b0, 32'h20, '0, '0);
    run_until_idle(50);
    chk("t2_rdata", rsp_rdata, 32'h12345678);
    chk("t2_resp", rsp_resp, 2'b00);
    chk("t2_rsp_vec", last_rsp_vec, 4'b0001);
    cfg_r = 0; use_rd = 0;

    // four continuous requesters after reset
    apply_reset(1'b0);
    grant_log.delete();
    req_mode = 2;
    for (int n = 0; n < 200 && grant_log.size() < 8; n++) step();
    req_mode = 0;
    run_until_idle(200);
    chk("t3_count", grant_log.size() >= 8, 1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("t3_order", grant_log[i], i % N);

    // AW late / W early, then the reverse
    cfg_aw = 3; cfg_w = 0;
    post_req(2, 1'b1, 32'h40, 32'hA5A5_0001, 4'h3);
    run_until_idle(50);
    chk("t4a_aw_cycles", aw_valid_cyc, 4);
    chk("t4a_w_cycles", w_valid_cyc, 1);
    cfg_aw = 0; cfg_w = 3;
    post_req(3, 1'b1, 32'h44, 32'h5A5A_0002, 4'hC);
    run_until_idle(50);
    chk("t4b_aw_cycles", aw_valid_cyc, 1);
    chk("t4b_w_cycles", w_valid_cyc, 4);
    cfg_w = 0;

    // error responses pass through to the right requester
    cfg_resp = 2;
    post_req(3, 1'b1, 32'h80, 32'h1, 4'h1);
    run_until_idle(50);
    chk("t5_bresp", rsp_resp, 2'b10);
    chk("t5_b_vec", last_rsp_vec, 4'b1000);
    cfg_resp = 3;
    post_req(1, 1'b0, 32'h84, '0, '0);
    run_until_idle(50);
    chk("t5_rresp", rsp_resp, 2'b11);
    chk("t5_r_vec", last_rsp_vec, 4'b0010);
    cfg_resp = 0;

    // reset while waiting for R
    cfg_r = 20;
    post_req(2, 1'b0, 32'hC0, '0, '0);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin step(); seen = axi_rready; end
    chk("t6_in_rd_data", seen, 1);
    step(); step();
    apply_reset(1'b1);
    grant_log.delete();
    cfg_r = 0;
    run_until_idle(100);
    chk("t6_first_grant", grant_log[0], 0);

    // randomized traffic with random waits, responses and stray handshakes
    req_mode = 1; rnd_wait = 1; cfg_resp = -1; junk = 1;
    repeat (3000) step();
    req_mode = 0;
    run_until_idle(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
